// File: rtl/param_seq_detector_if.sv
// Bus bundle for param_seq_detector: serial bit input, pattern load, and match outputs.
interface param_seq_detector_if #(
  parameter int unsigned PAT_LEN = 4,
  parameter int unsigned CNT_W   = 8
);
  logic               en;
  logic               j;
  logic               load;
  logic [PAT_LEN-1:0] pat_in;
  logic               overlap;
  logic               w;
  logic [CNT_W-1:0]   match_cnt;
  logic               full;

  // Bit source / controller side
  modport master (
    output en, j, load, pat_in, overlap,
    input  w, match_cnt, full
  );

  // Detector side
  modport slave (
    input  en, j, load, pat_in, overlap,
    output w, match_cnt, full
  );
endinterface

// File: rtl/param_seq_detector.sv
// Serial sequence detector with a runtime-loadable pattern, overlap/non-overlap modes and a
// saturating match counter. The window fills with PAT_LEN accepted bits before hunting.
module param_seq_detector #(
  parameter int unsigned       PAT_LEN     = 4,
  parameter int unsigned       CNT_W       = 8,
  parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 4'b1001
) (
  input logic                   clk,
  input logic                   rst,
  param_seq_detector_if.slave   bus
);

  localparam int unsigned FillW = $clog2(PAT_LEN + 1);
  localparam logic [FillW-1:0] FillLast = FillW'(PAT_LEN - 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_LEN);

  typedef enum logic {
    StFill = 1'b0,
    StHunt = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               w_q, w_d;

  logic [PAT_LEN-1:0] win;
  logic               eval;
  logic               hit;

  // Next-state: load wins over en; a match is only evaluated once the window is full
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    w_d     = 1'b0;
    win     = {hist_q[PAT_LEN-2:0], bus.j};
    eval    = 1'b0;
    hit     = 1'b0;

    if (bus.load) begin
      pat_d   = bus.pat_in;
      hist_d  = '0;
      fill_d  = '0;
      cnt_d   = '0;
      state_d = StFill;
    end else if (bus.en) begin
      hist_d = win;
      unique case (state_q)
        StFill: begin
          if (fill_q >= FillLast) begin
            eval = 1'b1;
          end else begin
            fill_d = fill_q + FillW'(1);
          end
        end
        StHunt: eval = 1'b1;
        default: begin
          state_d = StFill;
          hist_d  = '0;
          fill_d  = '0;
        end
      endcase

      if (eval) begin
        hit     = (win == pat_q);
        state_d = StHunt;
        fill_d  = FillFull;
        if (hit) begin
          w_d = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // Non-overlap mode demands PAT_LEN fresh bits before the next match
          if (!bus.overlap) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = StFill;
          end
        end
      end
    end
  end

  // State registers, asynchronously cleared to the default pattern
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFill;
      pat_q   <= DEFAULT_PAT;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      w_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
    end
  end

  assign bus.w         = w_q;
  assign bus.match_cnt = cnt_q;
  assign bus.full      = (state_q == StHunt);

endmodule

// File: tb/tb_param_seq_detector.sv
// Scoreboard bench: stimulus pushes expected match pulses, a negedge monitor pops and compares.
module tb_param_seq_detector;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  param_seq_detector_if #(.PAT_LEN(4), .CNT_W(8)) bus_a ();
  param_seq_detector_if #(.PAT_LEN(2), .CNT_W(2)) bus_b ();

  param_seq_detector #(
    .PAT_LEN    (4),
    .CNT_W      (8),
    .DEFAULT_PAT(4'b1001)
  ) u_dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a.slave)
  );

  param_seq_detector #(
    .PAT_LEN    (2),
    .CNT_W      (2),
    .DEFAULT_PAT(2'b11)
  ) u_dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every w pulse must match the oldest expected pulse in cycle and count
  always @(negedge clk) begin
    if (bus_a.w !== 1'b0) begin
      if (q_a.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_unexpected_w: got w=%b expected no pulse (cycle %0d)", bus_a.w, cyc);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_w_cycle", cyc, e.cyc);
        chk("a_w_cnt", 32'(bus_a.match_cnt), e.cnt);
      end
    end
    if (bus_b.w !== 1'b0) begin
      if (q_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_unexpected_w: got w=%b expected no pulse (cycle %0d)", bus_b.w, cyc);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_w_cycle", cyc, e.cyc);
        chk("b_w_cnt", 32'(bus_b.match_cnt), e.cnt);
      end
    end
  end

  task automatic acc_a(input logic jv, input logic exp_w, input int exp_cnt,
                       input logic exp_full, input string nm);
    bus_a.en   = 1'b1;
    bus_a.j    = jv;
    bus_a.load = 1'b0;
    @(posedge clk);
    #1;
    bus_a.en = 1'b0;
    if (exp_w) q_a.push_back('{cyc: cyc, cnt: exp_cnt});
    chk({nm, "_cnt"}, 32'(bus_a.match_cnt), exp_cnt);
    chk({nm, "_full"}, 32'(bus_a.full), 32'(exp_full));
  endtask

  task automatic gap_a(input int exp_cnt, input logic exp_full, input string nm);
    bus_a.en   = 1'b0;
    bus_a.j    = ~bus_a.j;
    bus_a.load = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, "_cnt"}, 32'(bus_a.match_cnt), exp_cnt);
    chk({nm, "_full"}, 32'(bus_a.full), 32'(exp_full));
  endtask

  // Load with en=1, j=1 in the same cycle; the bit must be dropped
  task automatic load_a(input logic [3:0] p, input string nm);
    bus_a.load   = 1'b1;
    bus_a.pat_in = p;
    bus_a.en     = 1'b1;
    bus_a.j      = 1'b1;
    @(posedge clk);
    #1;
    bus_a.load = 1'b0;
    bus_a.en   = 1'b0;
    chk({nm, "_cnt"}, 32'(bus_a.match_cnt), 0);
    chk({nm, "_full"}, 32'(bus_a.full), 0);
  endtask

  task automatic acc_b(input logic exp_w, input int exp_cnt, input logic exp_full,
                       input string nm);
    bus_b.en = 1'b1;
    bus_b.j  = 1'b1;
    @(posedge clk);
    #1;
    bus_b.en = 1'b0;
    if (exp_w) q_b.push_back('{cyc: cyc, cnt: exp_cnt});
    chk({nm, "_cnt"}, 32'(bus_b.match_cnt), exp_cnt);
    chk({nm, "_full"}, 32'(bus_b.full), 32'(exp_full));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    bus_a.en = 1'b0; bus_a.j = 1'b0; bus_a.load = 1'b0; bus_a.pat_in = '0; bus_a.overlap = 1'b1;
    bus_b.en = 1'b0; bus_b.j = 1'b0; bus_b.load = 1'b0; bus_b.pat_in = '0; bus_b.overlap = 1'b1;

    #3;
    chk("rst_a_w", 32'(bus_a.w), 0);
    chk("rst_a_cnt", 32'(bus_a.match_cnt), 0);
    chk("rst_a_full", 32'(bus_a.full), 0);
    chk("rst_b_cnt", 32'(bus_b.match_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // T1: default pattern, then async reset mid-stream
    acc_a(1'b1, 1'b0, 0, 1'b0, "t1_b1");
    acc_a(1'b0, 1'b0, 0, 1'b0, "t1_b2");
    acc_a(1'b0, 1'b0, 0, 1'b0, "t1_b3");
    acc_a(1'b1, 1'b1, 1, 1'b1, "t1_b4");
    acc_a(1'b1, 1'b0, 1, 1'b1, "t1_b5");
    acc_a(1'b0, 1'b0, 1, 1'b1, "t1_b6");
    #2;
    rst = 1'b0;
    #1;
    chk("t1_async_w", 32'(bus_a.w), 0);
    chk("t1_async_cnt", 32'(bus_a.match_cnt), 0);
    chk("t1_async_full", 32'(bus_a.full), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    acc_a(1'b1, 1'b0, 0, 1'b0, "t1_r1");
    acc_a(1'b0, 1'b0, 0, 1'b0, "t1_r2");
    acc_a(1'b0, 1'b0, 0, 1'b0, "t1_r3");
    acc_a(1'b1, 1'b1, 1, 1'b1, "t1_r4");

    // T2: overlapping matches share the trailing 1
    bus_a.overlap = 1'b1;
    load_a(4'b1001, "t2_load");
    acc_a(1'b1, 1'b0, 0, 1'b0, "t2_b1");
    acc_a(1'b0, 1'b0, 0, 1'b0, "t2_b2");
    acc_a(1'b0, 1'b0, 0, 1'b0, "t2_b3");
    acc_a(1'b1, 1'b1, 1, 1'b1, "t2_b4");
    acc_a(1'b0, 1'b0, 1, 1'b1, "t2_b5");
    acc_a(1'b0, 1'b0, 1, 1'b1, "t2_b6");
    acc_a(1'b1, 1'b1, 2, 1'b1, "t2_b7");

    // T3: non-overlapping, window restarts after the match
    bus_a.overlap = 1'b0;
    load_a(4'b1001, "t3_load");
    acc_a(1'b1, 1'b0, 0, 1'b0, "t3_b1");
    acc_a(1'b0, 1'b0, 0, 1'b0, "t3_b2");
    acc_a(1'b0, 1'b0, 0, 1'b0, "t3_b3");
    acc_a(1'b1, 1'b1, 1, 1'b0, "t3_b4");
    acc_a(1'b0, 1'b0, 1, 1'b0, "t3_b5");
    acc_a(1'b0, 1'b0, 1, 1'b0, "t3_b6");
    acc_a(1'b1, 1'b0, 1, 1'b0, "t3_b7");

    // T4: new pattern; load-cycle bit must not complete an early match
    bus_a.overlap = 1'b1;
    load_a(4'b1101, "t4_load1");
    acc_a(1'b1, 1'b0, 0, 1'b0, "t4_a1");
    acc_a(1'b1, 1'b0, 0, 1'b0, "t4_a2");
    acc_a(1'b0, 1'b0, 0, 1'b0, "t4_a3");
    acc_a(1'b1, 1'b1, 1, 1'b1, "t4_a4");
    load_a(4'b1101, "t4_load2");
    acc_a(1'b1, 1'b0, 0, 1'b0, "t4_c1");
    acc_a(1'b0, 1'b0, 0, 1'b0, "t4_c2");
    acc_a(1'b1, 1'b0, 0, 1'b0, "t4_c3");
    acc_a(1'b1, 1'b0, 0, 1'b1, "t4_c4");
    acc_a(1'b0, 1'b0, 0, 1'b1, "t4_c5");
    acc_a(1'b1, 1'b1, 1, 1'b1, "t4_c6");

    // T5: en gaps with j toggling are ignored
    load_a(4'b1001, "t5_load");
    acc_a(1'b1, 1'b0, 0, 1'b0, "t5_b1");
    gap_a(0, 1'b0, "t5_g1");
    gap_a(0, 1'b0, "t5_g2");
    acc_a(1'b0, 1'b0, 0, 1'b0, "t5_b2");
    gap_a(0, 1'b0, "t5_g3");
    acc_a(1'b0, 1'b0, 0, 1'b0, "t5_b3");
    gap_a(0, 1'b0, "t5_g4");
    gap_a(0, 1'b0, "t5_g5");
    acc_a(1'b1, 1'b1, 1, 1'b1, "t5_b4");
    gap_a(1, 1'b1, "t5_g6");
    gap_a(1, 1'b1, "t5_g7");

    // T6: 2-bit counter saturates at 3 while pulses keep coming
    acc_b(1'b0, 0, 1'b0, "t6_b1");
    acc_b(1'b1, 1, 1'b1, "t6_b2");
    acc_b(1'b1, 2, 1'b1, "t6_b3");
    acc_b(1'b1, 3, 1'b1, "t6_b4");
    acc_b(1'b1, 3, 1'b1, "t6_b5");
    acc_b(1'b1, 3, 1'b1, "t6_b6");
    acc_b(1'b1, 3, 1'b1, "t6_b7");

    repeat (3) @(posedge clk);
    #1;
    chk("a_missing_w", q_a.size(), 0);
    chk("b_missing_w", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
